// File: rtl/clk_en_gen.sv
// Programmable multi-channel clock-enable generator.
// Per-channel divided strobes and square waves, gated by a relock FSM.
module clk_en_gen #(
   parameter int NUM_CLOCKS  = 2,
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 2,
   parameter int LOCK_CYCLES = 16,
   localparam int CH_W = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [CH_W-1:0]       cfg_ch,
   input  logic [CNT_W-1:0]      cfg_div,
   input  logic [CNT_W-1:0]      cfg_phase,
   output logic [NUM_CLOCKS-1:0] outclk_en,
   output logic [NUM_CLOCKS-1:0] outclk,
   output logic                  locked
);

   typedef enum logic {
      LOCKING,
      LOCKED
   } lock_state_t;

   localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

   lock_state_t state_q, state_d;
   logic [15:0] lock_cnt_q, lock_cnt_d;
   logic        accept;
   logic        locked_d;

   logic [CNT_W-1:0] div_q [NUM_CLOCKS];
   logic [CNT_W-1:0] cnt_q [NUM_CLOCKS];
   logic [CNT_W-1:0] div_d [NUM_CLOCKS];
   logic [CNT_W-1:0] cnt_d [NUM_CLOCKS];
   logic [NUM_CLOCKS-1:0] en_d;
   logic [NUM_CLOCKS-1:0] clk_d;

   // Stored ratios of 0 and 1 both behave as divide-by-one.
   function automatic logic [CNT_W-1:0] eff_div(
      input logic [CNT_W-1:0] d
   );
      return (d < CNT_W'(2)) ? CNT_W'(1) : d;
   endfunction

   assign locked    = (state_q == LOCKED);
   assign cfg_ready = (state_q == LOCKED);
   assign accept    = cfg_valid & cfg_ready;

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      unique case (state_q)
         LOCKING: begin
            if (lock_cnt_q >= LOCK_LAST) begin
               state_d    = LOCKED;
               lock_cnt_d = '0;
            end else begin
               lock_cnt_d = lock_cnt_q + 16'd1;
            end
         end
         LOCKED: begin
            if (accept) begin
               state_d    = LOCKING;
               lock_cnt_d = '0;
            end
         end
      endcase
      locked_d = (state_d == LOCKED);
   end

   // Outputs are computed from next-state values so the registered
   // strobes line up with the counters they describe.
   always_comb begin
      en_d  = '0;
      clk_d = '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
         div_d[i] = div_q[i];
         cnt_d[i] = (cnt_q[i] >= eff_div(div_q[i]) - CNT_W'(1))
                  ? '0 : cnt_q[i] + CNT_W'(1);
         if (accept && (cfg_ch == CH_W'(i))) begin
            div_d[i] = cfg_div;
            cnt_d[i] = (cfg_phase >= eff_div(cfg_div))
                     ? '0 : cfg_phase;
         end
         en_d[i]  = locked_d &&
                    (cnt_d[i] == eff_div(div_d[i]) - CNT_W'(1));
         clk_d[i] = (cnt_d[i] < (eff_div(div_d[i]) >> 1));
      end
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         state_q    <= LOCKING;
         lock_cnt_q <= '0;
         outclk_en  <= '0;
         outclk     <= '0;
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            div_q[i] <= DIV_RST;
            cnt_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         outclk_en  <= en_d;
         outclk     <= clk_d;
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            div_q[i] <= div_d[i];
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule
